// File: rtl/branch_pkg.sv
// Shared types for the branch resolution slice: branch-type encoding,
// BHT counter states and the saturating counter step.
package branch_pkg;

  typedef enum logic [2:0] {
    B_NONE = 3'd0,
    B_BEQ  = 3'd1,
    B_BNE  = 3'd2,
    B_BLT  = 3'd3,
    B_BGE  = 3'd4,
    B_BLTU = 3'd5,
    B_BGEU = 3'd6
  } b_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RESET = WNT;

  // Encoding 7 is reserved and treated like NONE.
  function automatic logic is_branch(logic [2:0] t);
    return (t != 3'd0) && (t != 3'd7);
  endfunction

  function automatic logic [1:0] bht_next(logic [1:0] s, logic taken);
    if (taken) return (s == ST)  ? s : s + 2'd1;
    else       return (s == SNT) ? s : s - 2'd1;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters, indexed by pc[IDX_W+1:2].
// The read port is combinational and never bypasses a same-cycle update.
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_taken_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       tbl_q [BHT_DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_d;
  logic             unused_pc_bits;

  assign rd_idx         = rd_pc_i[IDX_W+1:2];
  assign upd_idx        = upd_pc_i[IDX_W+1:2];
  assign rd_taken_o     = tbl_q[rd_idx][1];
  assign upd_d          = bht_next(tbl_q[upd_idx], upd_taken_i);
  assign unused_pc_bits = ^{rd_pc_i, upd_pc_i};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < BHT_DEPTH; i++) tbl_q[i] <= BHT_RESET;
    end else if (upd_en_i) begin
      tbl_q[upd_idx] <= upd_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV32 conditional branches one cycle after execute, trains the BHT
// and keeps saturating branch / mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ex_valid,
  input  logic [2:0]       ex_branch_type,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic             stall,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             fetch_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [XLEN-1:0]  res_redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  logic             qualified;
  logic             taken;
  logic             mispredict;
  logic             upd_en;
  logic             res_valid_q, res_taken_q, res_mis_q;
  logic             res_valid_d, res_taken_d, res_mis_d;
  logic [XLEN-1:0]  redirect_q, redirect_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  assign qualified  = ex_valid & is_branch(ex_branch_type);
  assign mispredict = qualified & (taken != ex_pred_taken);
  assign upd_en     = qualified & ~stall;

  always_comb begin
    taken = 1'b0;
    case (b_t'(ex_branch_type))
      B_BEQ:   taken = (ex_rs1 == ex_rs2);
      B_BNE:   taken = (ex_rs1 != ex_rs2);
      B_BLT:   taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      B_BGE:   taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      B_BLTU:  taken = (ex_rs1 <  ex_rs2);
      B_BGEU:  taken = (ex_rs1 >= ex_rs2);
      default: taken = 1'b0;
    endcase
  end

  // Redirect target is only refreshed by a real branch; bubbles keep the last one.
  always_comb begin
    res_valid_d = qualified;
    res_taken_d = qualified & taken;
    res_mis_d   = mispredict;
    redirect_d  = redirect_q;
    br_cnt_d    = br_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    if (qualified) begin
      redirect_d = taken ? ex_target : ex_pc + XLEN'(4);
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mispredict && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_mis_q   <= 1'b0;
      redirect_q  <= '0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else if (!stall) begin
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      res_mis_q   <= res_mis_d;
      redirect_q  <= redirect_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  branch_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .XLEN      (XLEN)
  ) u_bht (
    .clk         (clk),
    .nrst        (nrst),
    .rd_pc_i     (fetch_pc),
    .rd_taken_o  (fetch_pred_taken),
    .upd_en_i    (upd_en),
    .upd_pc_i    (ex_pc),
    .upd_taken_i (taken)
  );

  assign res_valid        = res_valid_q;
  assign res_taken        = res_taken_q;
  assign res_mispredict   = res_mis_q;
  assign res_redirect_pc  = redirect_q;
  assign branch_count     = br_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios pinned to literals, then
// randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             nrst;
  logic             ex_valid;
  logic [2:0]       ex_branch_type;
  logic [XLEN-1:0]  ex_rs1, ex_rs2, ex_pc, ex_target;
  logic             ex_pred_taken;
  logic             stall;
  logic [XLEN-1:0]  fetch_pc;
  logic             fetch_pred_taken;
  logic             res_valid, res_taken, res_mispredict;
  logic [XLEN-1:0]  res_redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .ex_valid         (ex_valid),
    .ex_branch_type   (ex_branch_type),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .stall            (stall),
    .fetch_pc         (fetch_pc),
    .fetch_pred_taken (fetch_pred_taken),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_mispredict   (res_mispredict),
    .res_redirect_pc  (res_redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // ---------------- behavioural model ----------------
  int          m_bht [DEPTH];
  logic        m_valid = 1'b0, m_taken = 1'b0, m_mis = 1'b0;
  logic [31:0] m_rpc = '0;
  int          m_bcnt = 0, m_mcnt = 0;

  function automatic logic m_pred(logic [31:0] pc);
    return m_bht[(pc >> 2) % DEPTH] >= 2;
  endfunction

  function automatic logic m_decide(int t, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (t)
      1: return ua == ub;
      2: return ua != ub;
      3: return sa < sb;
      4: return sa >= sb;
      5: return ua < ub;
      6: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  initial for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;

  always @(posedge clk) begin
    int  t, idx;
    logic q, tk;
    if (!nrst) begin
      m_valid = 0; m_taken = 0; m_mis = 0; m_rpc = '0;
      m_bcnt = 0; m_mcnt = 0;
      for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    end else if (!stall) begin
      t  = int'(ex_branch_type);
      q  = ex_valid && t >= 1 && t <= 6;
      tk = m_decide(t, ex_rs1, ex_rs2);
      m_valid = q;
      m_taken = q && tk;
      m_mis   = q && (tk != ex_pred_taken);
      if (q) begin
        m_rpc = tk ? ex_target : ex_pc + 32'd4;
        idx = int'((ex_pc >> 2) % DEPTH);
        m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                        : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
        if (m_bcnt < CMAX) m_bcnt++;
        if (m_mis && m_mcnt < CMAX) m_mcnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int compared = 0;
  int mismatched = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] act,
                     input logic [31:0] model, input logic [31:0] lit);
    cmp({name, " dut"}, act, lit);
    cmp({name, " model"}, model, lit);
  endtask

  always @(negedge clk) begin
    cmp("res_valid",        32'(res_valid),        32'(m_valid));
    cmp("res_taken",        32'(res_taken),        32'(m_taken));
    cmp("res_mispredict",   32'(res_mispredict),   32'(m_mis));
    cmp("res_redirect_pc",  res_redirect_pc,       m_rpc);
    cmp("branch_count",     32'(branch_count),     32'(m_bcnt));
    cmp("mispredict_count", 32'(mispredict_count), 32'(m_mcnt));
    cmp("fetch_pred_taken", 32'(fetch_pred_taken), 32'(m_pred(fetch_pc)));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_br(input int t, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    ex_valid       = 1'b1;
    ex_branch_type = 3'(t);
    ex_rs1         = a;
    ex_rs2         = b;
    ex_pc          = pc;
    ex_target      = tgt;
    ex_pred_taken  = pred;
  endtask

  // One branch resolved on the next edge, then the execute slot is emptied.
  task automatic issue(input int t, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    drive_br(t, a, b, pc, tgt, pred);
    tick();
    ex_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nrst = 1'b0; ex_valid = 1'b0; ex_branch_type = 3'd0;
    ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_target = '0;
    ex_pred_taken = 1'b0; stall = 1'b0; fetch_pc = 32'h40;

    tick(); tick();
    nrst = 1'b1;
    @(negedge clk);
    pin("reset fetch_pred", 32'(fetch_pred_taken), 32'(m_pred(fetch_pc)), 0);
    pin("reset res_valid",  32'(res_valid),        32'(m_valid), 0);
    pin("reset mispredict", 32'(res_mispredict),   32'(m_mis),   0);
    pin("reset redirect",   res_redirect_pc,       m_rpc,        0);
    pin("reset br_count",   32'(branch_count),     32'(m_bcnt),  0);

    // BGE with equal operands is taken
    issue(4, 5, 5, 32'h40, 32'h100, 1'b0);
    @(negedge clk);
    pin("bge res_valid",  32'(res_valid),        32'(m_valid), 1);
    pin("bge res_taken",  32'(res_taken),        32'(m_taken), 1);
    pin("bge mispredict", 32'(res_mispredict),   32'(m_mis),   1);
    pin("bge redirect",   res_redirect_pc,       m_rpc,        32'h100);
    pin("bge mis_count",  32'(mispredict_count), 32'(m_mcnt),  1);
    pin("bge fetch_pred", 32'(fetch_pred_taken), 32'(m_pred(fetch_pc)), 1);

    // signed vs unsigned on the same operands
    issue(3, 32'hFFFF_FFFF, 1, 32'h44, 32'h300, 1'b1);
    @(negedge clk);
    pin("blt taken", 32'(res_taken), 32'(m_taken), 1);
    issue(5, 32'hFFFF_FFFF, 1, 32'h80, 32'h300, 1'b0);
    @(negedge clk);
    pin("bltu taken",      32'(res_taken),      32'(m_taken), 0);
    pin("bltu redirect",   res_redirect_pc,     m_rpc,        32'h84);
    pin("bltu mispredict", 32'(res_mispredict), 32'(m_mis),   0);

    // hysteresis on the entry shared by 0x40 and 0x80
    for (int i = 0; i < 4; i++) issue(1, 7, 7, 32'h40, 32'h200, 1'b1);
    @(negedge clk);
    pin("sat entry", 32'(m_bht[0]), 32'(m_bht[0]), 3);
    fetch_pc = 32'h80;
    #1 pin("alias pred", 32'(fetch_pred_taken), 32'(m_pred(fetch_pc)), 1);
    fetch_pc = 32'h40;
    issue(1, 7, 8, 32'h40, 32'h200, 1'b1);
    @(negedge clk);
    pin("one nt pred", 32'(fetch_pred_taken), 32'(m_pred(fetch_pc)), 1);
    issue(1, 7, 8, 32'h40, 32'h200, 1'b1);
    issue(1, 7, 8, 32'h40, 32'h200, 1'b1);
    @(negedge clk);
    pin("three nt pred", 32'(fetch_pred_taken), 32'(m_pred(fetch_pc)), 0);

    // stall holds everything, then the branch resolves exactly once
    tick();
    stall = 1'b1;
    fetch_pc = 32'h48;
    drive_br(2, 1, 2, 32'h48, 32'h400, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      pin("stall res_valid", 32'(res_valid),        32'(m_valid), 0);
      pin("stall br_count",  32'(branch_count),     32'(m_bcnt),  10);
      pin("stall pred",      32'(fetch_pred_taken), 32'(m_pred(fetch_pc)), 0);
    end
    stall = 1'b0;
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    pin("unstall res_valid",  32'(res_valid),        32'(m_valid), 1);
    pin("unstall mispredict", 32'(res_mispredict),   32'(m_mis),   1);
    pin("unstall br_count",   32'(branch_count),     32'(m_bcnt),  11);
    pin("unstall mis_count",  32'(mispredict_count), 32'(m_mcnt),  5);
    tick();
    @(negedge clk);
    pin("once res_valid", 32'(res_valid),    32'(m_valid), 0);
    pin("once br_count",  32'(branch_count), 32'(m_bcnt),  11);

    // reset lands on the edge that would resolve a mispredicting branch
    drive_br(2, 1, 2, 32'h48, 32'h400, 1'b0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    ex_valid = 1'b0;
    @(negedge clk);
    pin("rst mispredict", 32'(res_mispredict),   32'(m_mis),  0);
    pin("rst br_count",   32'(branch_count),     32'(m_bcnt), 0);
    pin("rst mis_count",  32'(mispredict_count), 32'(m_mcnt), 0);
    for (int i = 0; i < DEPTH; i++) begin
      fetch_pc = 32'(i * 4);
      #0.2 pin("rst entry pred", 32'(fetch_pred_taken), 32'(m_pred(fetch_pc)), 0);
    end

    // randomized traffic; one mid-run reset, counters are driven into saturation
    for (int c = 0; c < 600; c++) begin
      tick();
      nrst           = (c != 300);
      ex_valid       = ($urandom_range(0, 9) < 7);
      ex_branch_type = 3'($urandom_range(0, 7));
      ex_rs1         = $urandom;
      ex_rs2         = ($urandom_range(0, 3) == 0) ? ex_rs1 : $urandom;
      if ($urandom_range(0, 3) == 0) ex_rs2 = ex_rs1 ^ 32'h8000_0000;
      ex_pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFF);
      ex_target      = $urandom;
      ex_pred_taken  = 1'($urandom_range(0, 1));
      stall          = ($urandom_range(0, 4) == 0);
      fetch_pc       = $urandom & 32'hFF;
    end
    tick();
    ex_valid = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    pin("sat br_count", 32'(branch_count), 32'(m_bcnt), CMAX);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
